// File: rtl/div_scheduler.sv
// div_scheduler: round-robin arbiter that shares one multi-cycle divider
// among NV oscillator voices. Pending requests are latched per voice,
// granted in rotating order, issued to the divider, and the quotient is
// captured into that voice's slice of q_out.
// Optional feature: define DIV_SCHED_TIMEOUT_EN to abandon a division that
// does not complete within TMO WAIT cycles and raise the sticky err flag.
module div_scheduler #(
    parameter int NV  = 4,
    parameter int TMO = 40
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [NV-1:0]    req,
    input  logic [NV*19-1:0] count_bus,
    input  logic [NV*19-1:0] dsor_bus,
    output logic             div_sample,
    output logic [18:0]      div_count,
    output logic [18:0]      div_dsor,
    input  logic             div_done,
    input  logic [8:0]       div_q,
    output logic [NV*9-1:0]  q_out,
    output logic [NV-1:0]    q_valid,
    output logic             busy,
    output logic             err
);

    localparam int SW = $clog2(NV);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t        state, state_next;
    logic [NV-1:0] pend;
    logic [NV-1:0] grant_mask;
    logic [SW-1:0] sel;
    logic [SW-1:0] ptr;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] cand;
    logic          grant_found;
    logic          grant;
    logic          timeout;

    // Round-robin search: first pending voice above the last winner, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NV; k++) begin
            cand = SW'((int'(ptr) + k) % NV);
            if (!grant_found && pend[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant = (state == IDLE) && grant_found;

    // One-hot clear mask for the voice being granted this cycle.
    always_comb begin
        grant_mask = '0;
        if (grant) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a done seen during ISSUE is ignored because ISSUE always moves to WAIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    begin
                if (div_done) begin
                    state_next = CAPTURE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from state (and the registered winner) only.
    always_comb begin
        div_sample = (state == ISSUE);
        busy       = (state != IDLE);
        q_valid    = '0;
        if (state == CAPTURE) begin
            q_valid[sel] = 1'b1;
        end
    end

    // Pending bits, grant bookkeeping, divider operands and result capture.
    always_ff @(posedge clk) begin
        // NOTE: the quotient array is reset because it is a visible output that must read 0 after reset.
        if (!RST) begin
            pend      <= '0;
            sel       <= '0;
            ptr       <= SW'(NV - 1);
            div_count <= '0;
            div_dsor  <= '0;
            q_out     <= '0;
        end else begin
            // A new request wins over a same-cycle grant clear, so no request is lost.
            pend <= (pend & ~grant_mask) | req;
            if (grant) begin
                sel       <= grant_idx;
                ptr       <= grant_idx;
                div_count <= count_bus[int'(grant_idx) * 19 +: 19];
                div_dsor  <= dsor_bus[int'(grant_idx) * 19 +: 19];
            end
            if (state == WAIT && div_done) begin
                q_out[int'(sel) * 9 +: 9] <= div_q;
            end
        end
    end

`ifdef DIV_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);

    logic [TW-1:0] tmo;

    assign timeout = (state == WAIT) && (tmo == TW'(TMO - 1));

    // WAIT cycle counter (cleared on entry) and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!RST) begin
            tmo <= '0;
            err <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmo <= '0;
            end else if (state == WAIT) begin
                tmo <= tmo + TW'(1);
            end
            if (timeout && !div_done) begin
                err <= 1'b1;
            end
        end
    end
`else
    // Constant false: without the timeout WAIT lasts until div_done and TMO has no effect.
    assign timeout = (TMO < 0);
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_div_scheduler.sv
// Testbench for div_scheduler: table of single-voice transactions followed by
// hand-written contention, fairness, request-during-WAIT, reset and (when
// DIV_SCHED_TIMEOUT_EN is defined) timeout sequences. A behavioural divider
// answers div_sample; a scoreboard queue holds the expected voice/quotient of
// each transaction and is popped on every q_valid pulse.
module tb_div_scheduler;

    localparam int NV  = 4;
    localparam int TMO = 40;

    logic             clk = 1'b0;
    logic             RST = 1'b0;
    logic [NV-1:0]    req = '0;
    logic [NV*19-1:0] count_bus = '0;
    logic [NV*19-1:0] dsor_bus = '0;
    logic             div_sample;
    logic [18:0]      div_count;
    logic [18:0]      div_dsor;
    logic             div_done = 1'b0;
    logic [8:0]       div_q = '0;
    logic [NV*9-1:0]  q_out;
    logic [NV-1:0]    q_valid;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    div_scheduler #(.NV(NV), .TMO(TMO)) dut (
        .clk        (clk),
        .RST        (RST),
        .req        (req),
        .count_bus  (count_bus),
        .dsor_bus   (dsor_bus),
        .div_sample (div_sample),
        .div_count  (div_count),
        .div_dsor   (div_dsor),
        .div_done   (div_done),
        .div_q      (div_q),
        .q_out      (q_out),
        .q_valid    (q_valid),
        .busy       (busy),
        .err        (err)
    );

    typedef struct {
        int         voice;
        logic [8:0] q;
    } exp_t;

    typedef struct {
        int          voice;
        logic [18:0] cnt;
        logic [18:0] dsor;
        int          lat;
        bit          spur;
        logic [8:0]  q;
    } vec_t;

    exp_t            sb[$];
    exp_t            popped;
    logic [8:0]      q_exp[NV];
    logic [NV*9-1:0] q_all;
    int              n_checks = 0;
    int              n_fail = 0;
    int              sample_cnt = 0;
    bit              prev_sample = 1'b0;

    // Divider model controls.
    int              div_lat = 1;
    bit              div_respond = 1'b1;
    bit              div_spurious = 1'b0;
    int              busy_cnt = 0;
    logic [8:0]      resp_q = '0;

    function automatic logic [8:0] div_model(input logic [18:0] c, input logic [18:0] d);
        logic [26:0] num;
        num = {c, 8'h00};
        return 9'(num / 27'(d));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: answers div_lat cycles after div_sample; optional bogus done during ISSUE.
    always @(negedge clk) begin
        div_done = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0 && div_respond) begin
                div_done = 1'b1;
                div_q    = resp_q;
            end
        end
        if (div_sample) begin
            busy_cnt = div_lat;
            resp_q   = div_model(div_count, div_dsor);
            if (div_spurious) begin
                div_done = 1'b1;
                div_q    = 9'h1FF;
            end
        end
    end

    // Output monitor: div_sample width, q_valid one-hot, scoreboard pop and full q_out compare.
    always @(negedge clk) begin
        if (div_sample) begin
            sample_cnt++;
            check("div_sample_single_cycle", 64'(prev_sample), 0);
        end
        prev_sample = div_sample;
        if (q_valid != '0) begin
            check("q_valid_onehot", 64'($countones(q_valid)), 1);
            if (sb.size() == 0) begin
                check("q_valid_unexpected", 64'(q_valid), 0);
            end else begin
                popped = sb.pop_front();
                check("q_valid_voice", 64'(q_valid), 64'(1) << popped.voice);
                q_exp[popped.voice] = popped.q;
                for (int v = 0; v < NV; v++) q_all[9*v +: 9] = q_exp[v];
                check("q_out_all", 64'(q_out), 64'(q_all));
            end
        end
    end

    task automatic set_voice(input int v, input logic [18:0] c, input logic [18:0] d);
        count_bus[19*v +: 19] = c;
        dsor_bus[19*v +: 19]  = d;
    endtask

    task automatic scramble_buses();
        for (int v = 0; v < NV; v++) set_voice(v, 19'($urandom), 19'($urandom) | 19'h1);
    endtask

    task automatic push_exp(input int v);
        sb.push_back('{v, div_model(count_bus[19*v +: 19], dsor_bus[19*v +: 19])});
    endtask

    task automatic do_reset();
        RST = 1'b0;
        req = '0;
        @(negedge clk);
        RST = 1'b1;
        sb.delete();
        for (int v = 0; v < NV; v++) q_exp[v] = '0;
    endtask

    task automatic pulse_req(input logic [NV-1:0] m);
        req = m;
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c;
        c = 0;
        while (c < budget && !(sb.size() == 0 && !busy)) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) check({name, "_wait_idle"}, 64'({sb.size() != 0, busy}), 0);
    endtask

    task automatic wait_sample(input string name, input int budget);
        int c;
        c = 0;
        while (c < budget && !div_sample) begin
            @(negedge clk);
            c++;
        end
        check({name, "_issue_seen"}, 64'(div_sample), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[4];
    int   s0;
    int   n;

    initial begin
        vecs[0] = '{1, 19'h00100, 19'h00200, 1, 1'b0, 9'h080};
        vecs[1] = '{0, 19'h7FFFF, 19'h7FFFF, 3, 1'b0, 9'h100};
        vecs[2] = '{3, 19'h00001, 19'h7FFFF, 5, 1'b1, 9'h000};
        vecs[3] = '{2, 19'h12345, 19'h00400, 2, 1'b1, 9'h0D1};
        for (int v = 0; v < NV; v++) q_exp[v] = '0;

        // Power-on reset state.
        repeat (2) @(negedge clk);
        check("rst_q_out", 64'(q_out), 0);
        check("rst_q_valid", 64'(q_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_div_sample", 64'(div_sample), 0);
        check("rst_err", 64'(err), 0);
        RST = 1'b1;
        @(negedge clk);

        // Table-driven single-voice transactions with latency checks.
        for (int i = 0; i < 4; i++) begin
            div_lat      = vecs[i].lat;
            div_spurious = vecs[i].spur;
            scramble_buses();
            set_voice(vecs[i].voice, vecs[i].cnt, vecs[i].dsor);
            sb.push_back('{vecs[i].voice, vecs[i].q});
            s0 = sample_cnt;
            pulse_req(NV'(1) << vecs[i].voice);
            check("lat_idle_after_req", 64'(busy), 0);
            @(negedge clk);
            check("lat_issue", 64'(div_sample), 1);
            check("div_count_operand", 64'(div_count), 64'(vecs[i].cnt));
            check("div_dsor_operand", 64'(div_dsor), 64'(vecs[i].dsor));
            repeat (vecs[i].lat) @(negedge clk);
            check("lat_no_valid_before_done", 64'(q_valid), 0);
            @(negedge clk);
            check("lat_valid_after_done", 64'(q_valid), 64'(1) << vecs[i].voice);
            wait_idle("single", 50);
            check("single_sample_count", 64'(sample_cnt - s0), 1);
            check("operands_held", 64'({div_count, div_dsor}), 64'({vecs[i].cnt, vecs[i].dsor}));
        end
        div_spurious = 1'b0;

        // Reset after activity clears every visible register.
        do_reset();
        check("rst2_q_out", 64'(q_out), 0);
        check("rst2_operands", 64'({div_count, div_dsor}), 0);
        check("rst2_busy", 64'(busy), 0);
        check("rst2_err", 64'(err), 0);

        // Contention: all four in one cycle, granted 0,1,2,3.
        div_lat = 2;
        scramble_buses();
        for (int v = 0; v < NV; v++) push_exp(v);
        s0 = sample_cnt;
        pulse_req('1);
        wait_idle("contention", 200);
        check("contention_samples", 64'(sample_cnt - s0), 4);

        // Fairness: voice 0 held, voice 2 pulsed once -> order 0,2,0,0.
        do_reset();
        scramble_buses();
        push_exp(0); push_exp(2); push_exp(0); push_exp(0);
        s0 = sample_cnt;
        n = 0;
        req = 4'b0001;
        for (int c = 0; c < 200 && n < 3; c++) begin
            @(negedge clk);
            if (div_sample) begin
                n++;
                if (n == 1) begin
                    req = 4'b0101;
                    @(negedge clk);
                    req = 4'b0001;
                end
            end
        end
        req = '0;
        check("fair_grants_seen", 64'(n), 3);
        wait_idle("fairness", 200);
        check("fair_samples", 64'(sample_cnt - s0), 4);

        // Request arriving during WAIT is served next.
        do_reset();
        div_lat = 4;
        scramble_buses();
        set_voice(3, 19'h01000, 19'h04000);
        push_exp(0);
        sb.push_back('{3, 9'h040});
        pulse_req(4'b0001);
        wait_sample("wait_req", 20);
        @(negedge clk);
        pulse_req(4'b1000);
        wait_idle("wait_req", 200);
        check("wait_req_q3", 64'(q_out[35:27]), 64'(9'h040));

        // Reset mid-WAIT: late divider result must be discarded.
        do_reset();
        div_lat = 6;
        scramble_buses();
        s0 = sample_cnt;
        pulse_req(4'b0010);
        wait_sample("rst_wait", 20);
        repeat (2) @(negedge clk);
        check("rst_wait_busy_before", 64'(busy), 1);
        RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("rst_wait_no_valid", 64'(q_valid), 0);
        end
        check("rst_wait_q_out", 64'(q_out), 0);
        check("rst_wait_idle", 64'(busy), 0);
        check("rst_wait_no_regrant", 64'(sample_cnt - s0), 1);

`ifdef DIV_SCHED_TIMEOUT_EN
        // Timeout: divider never answers; err after TMO WAIT cycles, then normal service.
        do_reset();
        div_lat = 1;
        div_respond = 1'b0;
        scramble_buses();
        pulse_req(4'b0100);
        wait_sample("tmo", 20);
        for (int c = 1; c <= TMO + 1; c++) begin
            @(negedge clk);
            if (c == TMO) check("tmo_err_not_early", 64'(err), 0);
        end
        check("tmo_err_set", 64'(err), 1);
        check("tmo_idle", 64'(busy), 0);
        check("tmo_q_out_kept", 64'(q_out), 0);
        div_respond = 1'b1;
        push_exp(1);
        pulse_req(4'b0010);
        wait_idle("tmo_after", 50);
        check("tmo_err_sticky", 64'(err), 1);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter NV, default 4, number of voices sharing one divider; legal range 2..8.
REQ-002 Parameter TMO, default 40, cycles WAIT tolerates without div_done.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 RST  input  1  synchronous, active-low reset.
REQ-005 req  input  NV  per-voice sample request pulses; bit i belongs to voice i.
REQ-006 count_bus  input  NV*19  packed oscillator counts; voice i occupies bits [19i+18:19i].
REQ-007 dsor_bus  input  NV*19  packed frequency-table divisors; same packing as count_bus.
REQ-008 div_sample  output  1  one-cycle start pulse to the divider.
REQ-009 div_count, div_dsor  output  19 each  operands driven to the divider.
REQ-010 div_done  input  1  divider result-ready flag.
REQ-011 div_q  input  9  divider quotient.
REQ-012 q_out  output  NV*9  per-voice registered quotients; voice i at [9i+8:9i].
REQ-013 q_valid  output  NV  one-cycle pulse: q_out slice i updated.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 pend[NV] register: req[i]=1 sets pend[i]; a grant clears pend[i]; set and clear in the same cycle leaves pend[i]=1.
REQ-017 States: IDLE, ISSUE, WAIT, CAPTURE; busy = (state != IDLE).
REQ-018 IDLE -> ISSUE when any pend bit is set.
- Grant: first set pend bit searching upward from ptr+1, modulo NV.
- Grant latched in sel; ptr <= sel; pend[sel] cleared.
REQ-019 ISSUE: div_sample=1 for exactly one cycle; next state WAIT.
REQ-020 div_count and div_dsor = slices sel of count_bus and dsor_bus, registered at the IDLE->ISSUE edge and held constant until the next grant.
REQ-021 WAIT: tmo counter clears on entry and increments each cycle.
- div_done=1 -> CAPTURE; q_out slice sel <= div_q on that edge.
- div_done seen in the ISSUE cycle is ignored.
REQ-022 CAPTURE: q_valid[sel]=1 for one cycle, all other q_valid bits 0; next state IDLE.
REQ-023 Throughput: one division per transaction; a pend bit still set in IDLE is granted on the next edge.
REQ-024 A req arriving while busy is never lost; it is serviced in a later transaction in round-robin order.
REQ-025 Latency, req[i] pulse at edge k with the FSM idle and no other pend bit set:
- pend set at edge k.
- ISSUE entered at edge k+1.
- div_sample high in cycle k+1..k+2.
- q_valid[i] pulses in the cycle after div_done is sampled.
REQ-026 div_sample and q_valid are Moore outputs decoded from state only; no combinational input-to-output path.

Reset
REQ-027 RST=0 at a clock edge forces, regardless of state (including mid-WAIT):
- state=IDLE; pend=0; sel=0; ptr=NV-1, so voice 0 wins first.
- div_sample=0; div_count=0; div_dsor=0.
- q_out=0; q_valid=0; err=0; tmo=0.
REQ-028 An in-flight divider result arriving after reset is discarded; q_out remains 0.

Configuration
REQ-029 Macro DIV_SCHED_TIMEOUT_EN.
- Defined: in WAIT, tmo reaching TMO without div_done sets err (sticky until reset), leaves q_out unchanged, emits no q_valid, and returns to IDLE.
- Undefined: WAIT waits indefinitely; err is tied to 0; the tmo counter is not implemented.

Verification
REQ-030 Single voice: NV=4, voice 1 count=0x00100, dsor=0x00200; pulse req[1]; divider model returns 0x080 -> q_out[17:9]=0x080, q_valid=4'b0010 for one cycle, div_sample exactly one pulse.
REQ-031 Contention: req=4'b1111 in one cycle after reset -> grants in order 0,1,2,3; each q_valid a one-hot pulse; four div_sample pulses total.
REQ-032 Fairness: voice 0 requests continuously and voice 2 pulses once -> voice 2 is granted no later than the second transaction after its request.
REQ-033 Request during WAIT: req[3] pulses while voice 0 is in WAIT -> voice 3 is served next; count=0x01000, dsor=0x04000 -> q_out[35:27]=0x040.
REQ-034 Reset mid-WAIT: RST=0 for one edge during WAIT, then the divider asserts done -> no q_valid, q_out=0, state IDLE, pend=0.
REQ-035 With DIV_SCHED_TIMEOUT_EN defined and the divider model never asserting done -> err=1 after TMO WAIT cycles, FSM in IDLE, the next request is serviced normally, err stays 1.
